// File: rtl/segre_hazard_ctrl.sv
// Pipeline sequencing controller for the Segre core: stage hold/bubble controls
// for memory-wait stalls, taken-branch redirects with flush, and load-use hazards.
module segre_hazard_ctrl #(
  parameter int unsigned REG_SIZE     = 5,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [REG_SIZE-1:0]  id_rs1_addr_i,
  input  logic [REG_SIZE-1:0]  id_rs2_addr_i,
  input  logic                 id_rs1_use_i,
  input  logic                 id_rs2_use_i,
  input  logic                 ex_memop_rd_i,
  input  logic [REG_SIZE-1:0]  ex_rf_waddr_i,
  input  logic                 tkbr_i,
  input  logic                 mem_req_i,
  input  logic                 mem_ready_i,
  output logic                 block_if_o,
  output logic                 block_id_o,
  output logic                 block_ex_o,
  output logic                 block_mem_o,
  output logic                 inject_nops_id_o,
  output logic                 inject_nops_ex_o,
  output logic                 pc_redirect_o,
  output logic                 kill_if_o,
  output logic [CNT_WIDTH-1:0] stall_cycles_o,
  output logic [CNT_WIDTH-1:0] flush_count_o
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_e;

  localparam logic [2:0]           FCNT_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam bit                   MULTI_FLUSH = (FLUSH_CYCLES > 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [2:0]            fcnt_q, fcnt_d;
  logic                  pend_q, pend_d;
  logic [CNT_WIDTH-1:0]  stall_q, flush_q;

  logic mem_wait, load_use;
  logic blk_all, blk_lu, redir, flush_bubble;

  assign mem_wait = mem_req_i & ~mem_ready_i;
  assign load_use = ex_memop_rd_i && (ex_rf_waddr_i != '0) &&
                    ((id_rs1_use_i && (id_rs1_addr_i == ex_rf_waddr_i)) ||
                     (id_rs2_use_i && (id_rs2_addr_i == ex_rf_waddr_i)));

  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    pend_d       = pend_q;
    blk_all      = 1'b0;
    blk_lu       = 1'b0;
    redir        = 1'b0;
    flush_bubble = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_wait) begin
          blk_all = 1'b1;
          state_d = MEM_WAIT;
          if (tkbr_i) pend_d = 1'b1;
        end else if (tkbr_i) begin
          redir = 1'b1;
        end else if (load_use) begin
          blk_lu = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready_i) begin
          blk_all = 1'b1;
          if (tkbr_i) pend_d = 1'b1;
        end else if (pend_q || tkbr_i) begin
          redir = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (mem_wait) begin
          blk_all = 1'b1;
          state_d = MEM_WAIT;
          if (tkbr_i) pend_d = 1'b1;
        end else if (tkbr_i) begin
          redir = 1'b1;
        end else begin
          flush_bubble = 1'b1;
          fcnt_d       = fcnt_q - 3'd1;
          if (fcnt_q <= 3'd1) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    // A redirect from any state shares the same bookkeeping.
    if (redir) begin
      pend_d = 1'b0;
      if (MULTI_FLUSH) begin
        fcnt_d  = FCNT_RELOAD;
        state_d = FLUSH;
      end else begin
        state_d = RUN;
      end
    end
  end

  assign block_if_o       = ~rst_i & (blk_all | blk_lu);
  assign block_id_o       = ~rst_i & (blk_all | blk_lu);
  assign block_ex_o       = ~rst_i & blk_all;
  assign block_mem_o      = ~rst_i & blk_all;
  assign inject_nops_id_o = rst_i | redir | flush_bubble | blk_lu;
  assign inject_nops_ex_o = rst_i;
  assign pc_redirect_o    = ~rst_i & redir;
  assign kill_if_o        = rst_i | redir | flush_bubble;
  assign stall_cycles_o   = stall_q;
  assign flush_count_o    = flush_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      fcnt_q  <= 3'd0;
      pend_q  <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      pend_q  <= pend_d;
      if ((blk_all || blk_lu) && (stall_q != '1)) stall_q <= stall_q + CNT_ONE;
      if (redir && (flush_q != '1)) flush_q <= flush_q + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_segre_hazard_ctrl.sv
// Directed-vector bench for segre_hazard_ctrl; a second instance covers
// FLUSH_CYCLES=1 and 4-bit counter saturation.
module tb_segre_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, waddr;
  logic       use1, use2, memop_rd, tkbr, mem_req, mem_ready;

  logic        b_if, b_id, b_ex, b_mem, inj_id, inj_ex, redir, kill;
  logic [31:0] stall_cnt, flush_cnt;
  logic        b_if2, b_id2, b_ex2, b_mem2, inj_id2, inj_ex2, redir2, kill2;
  logic [3:0]  stall_cnt2, flush_cnt2;

  // Control bits: {block_if, block_id, block_ex, block_mem, inj_id, inj_ex, redirect, kill}
  logic [7:0] ctl, ctl2;
  assign ctl  = {b_if, b_id, b_ex, b_mem, inj_id, inj_ex, redir, kill};
  assign ctl2 = {b_if2, b_id2, b_ex2, b_mem2, inj_id2, inj_ex2, redir2, kill2};

  localparam logic [7:0] C_RESET = 8'b0000_1101;
  localparam logic [7:0] C_IDLE  = 8'b0000_0000;
  localparam logic [7:0] C_LU    = 8'b1100_1000;
  localparam logic [7:0] C_WAIT  = 8'b1111_0000;
  localparam logic [7:0] C_REDIR = 8'b0000_1011;
  localparam logic [7:0] C_FLUSH = 8'b0000_1001;

  int total = 0;
  int bad   = 0;

  // clock / reset
  always #5 clk = ~clk;

  segre_hazard_ctrl #(.REG_SIZE(5), .FLUSH_CYCLES(2), .CNT_WIDTH(32)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
    .id_rs1_use_i(use1), .id_rs2_use_i(use2),
    .ex_memop_rd_i(memop_rd), .ex_rf_waddr_i(waddr),
    .tkbr_i(tkbr), .mem_req_i(mem_req), .mem_ready_i(mem_ready),
    .block_if_o(b_if), .block_id_o(b_id), .block_ex_o(b_ex), .block_mem_o(b_mem),
    .inject_nops_id_o(inj_id), .inject_nops_ex_o(inj_ex),
    .pc_redirect_o(redir), .kill_if_o(kill),
    .stall_cycles_o(stall_cnt), .flush_count_o(flush_cnt)
  );

  segre_hazard_ctrl #(.REG_SIZE(5), .FLUSH_CYCLES(1), .CNT_WIDTH(4)) u_dut2 (
    .clk_i(clk), .rst_i(rst),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
    .id_rs1_use_i(use1), .id_rs2_use_i(use2),
    .ex_memop_rd_i(memop_rd), .ex_rf_waddr_i(waddr),
    .tkbr_i(tkbr), .mem_req_i(mem_req), .mem_ready_i(mem_ready),
    .block_if_o(b_if2), .block_id_o(b_id2), .block_ex_o(b_ex2), .block_mem_o(b_mem2),
    .inject_nops_id_o(inj_id2), .inject_nops_ex_o(inj_ex2),
    .pc_redirect_o(redir2), .kill_if_o(kill2),
    .stall_cycles_o(stall_cnt2), .flush_count_o(flush_cnt2)
  );

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rs1 = '0; rs2 = '0; waddr = '0;
    use1 = 1'b0; use2 = 1'b0; memop_rd = 1'b0;
    tkbr = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();

    // Reset values
    settle();
    check("reset_ctl", 32'(ctl), 32'(C_RESET));
    cyc();
    check("reset_stall", stall_cnt, 32'd0);
    check("reset_flush", flush_cnt, 32'd0);
    rst = 1'b0;
    settle();
    check("idle_ctl", 32'(ctl), 32'(C_IDLE));

    // Load-use on rs2
    cyc();
    memop_rd = 1'b1; waddr = 5'd5; rs2 = 5'd5; use2 = 1'b1;
    settle();
    check("lu_ctl", 32'(ctl), 32'(C_LU));
    cyc();
    clear_inputs();
    settle();
    check("lu_one_cycle", 32'(ctl), 32'(C_IDLE));
    check("lu_stall_cnt", stall_cnt, 32'd1);
    // Destination x0 never stalls
    memop_rd = 1'b1; waddr = 5'd0; rs2 = 5'd0; use2 = 1'b1;
    settle();
    check("lu_x0", 32'(ctl), 32'(C_IDLE));
    // Match on rs1 with its use flag clear: no stall
    waddr = 5'd7; rs1 = 5'd7; use1 = 1'b0; rs2 = 5'd3;
    settle();
    check("lu_nouse", 32'(ctl), 32'(C_IDLE));
    use1 = 1'b1;
    settle();
    check("lu_rs1", 32'(ctl), 32'(C_LU));
    cyc();
    clear_inputs();

    // Memory wait: 3 wait cycles then ready
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("mw_wait%0d", i), 32'(ctl), 32'(C_WAIT));
      cyc();
    end
    mem_ready = 1'b1;
    settle();
    check("mw_ready", 32'(ctl), 32'(C_IDLE));
    cyc();
    clear_inputs();
    check("mw_stall_cnt", stall_cnt, 32'd3);
    // ready without request is ignored
    mem_ready = 1'b1;
    settle();
    check("mw_ready_noreq", 32'(ctl), 32'(C_IDLE));
    cyc();
    clear_inputs();

    // Redirect, FLUSH_CYCLES=2 (u_dut) and 1 (u_dut2)
    do_reset();
    tkbr = 1'b1;
    settle();
    check("rd_c0", 32'(ctl), 32'(C_REDIR));
    check("rd1_c0", 32'(ctl2), 32'(C_REDIR));
    cyc();
    tkbr = 1'b0;
    settle();
    check("rd_c1", 32'(ctl), 32'(C_FLUSH));
    check("rd1_c1", 32'(ctl2), 32'(C_IDLE));
    check("rd_flush_cnt", flush_cnt, 32'd1);
    check("rd1_flush_cnt", 32'(flush_cnt2), 32'd1);
    cyc();
    settle();
    check("rd_c2", 32'(ctl), 32'(C_IDLE));

    // Redirect during memory wait
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    settle();
    check("rmw_c1", 32'(ctl), 32'(C_WAIT));
    cyc();
    tkbr = 1'b1;
    settle();
    check("rmw_c2", 32'(ctl), 32'(C_WAIT));
    cyc();
    tkbr = 1'b0;
    settle();
    check("rmw_c3", 32'(ctl), 32'(C_WAIT));
    cyc();
    mem_ready = 1'b1;
    settle();
    check("rmw_c4", 32'(ctl), 32'(C_REDIR));
    cyc();
    clear_inputs();
    settle();
    check("rmw_c5", 32'(ctl), 32'(C_FLUSH));
    check("rmw_flush_cnt", flush_cnt, 32'd1);
    check("rmw_stall_cnt", stall_cnt, 32'd3);
    cyc();
    settle();
    check("rmw_c6", 32'(ctl), 32'(C_IDLE));

    // Memory wait and taken branch in the same RUN cycle: wait wins, redirect deferred
    do_reset();
    mem_req = 1'b1; tkbr = 1'b1;
    settle();
    check("mwtk_c0", 32'(ctl), 32'(C_WAIT));
    cyc();
    tkbr = 1'b0; mem_ready = 1'b1;
    settle();
    check("mwtk_c1", 32'(ctl), 32'(C_REDIR));
    cyc();
    clear_inputs();

    // Reset mid-FLUSH
    do_reset();
    tkbr = 1'b1;
    cyc();
    tkbr = 1'b0;
    settle();
    check("rf_in_flush", 32'(ctl), 32'(C_FLUSH));
    rst = 1'b1;
    settle();
    check("rf_reset_ctl", 32'(ctl), 32'(C_RESET));
    cyc();
    rst = 1'b0;
    settle();
    check("rf_after_ctl", 32'(ctl), 32'(C_IDLE));
    check("rf_after_flush", flush_cnt, 32'd0);
    check("rf_after_stall", stall_cnt, 32'd0);
    cyc();

    // Saturation of the 4-bit stall counter
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 18; i++) cyc();
    check("sat_stall4", 32'(stall_cnt2), 32'd15);
    check("sat_stall32", stall_cnt, 32'd18);
    mem_ready = 1'b1;
    cyc();
    clear_inputs();
    check("sat_hold", 32'(stall_cnt2), 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
